// File: rtl/uart_matmul_engine.sv
// Runtime-sized square matrix multiplier between a UART receiver and transmitter.
// Loads N, A and B as a byte stream, computes R = A x B one MAC per cycle, streams R back.
module uart_matmul_engine #(
    parameter int unsigned MAX_N       = 10,
    parameter int unsigned ELEM_W      = 8,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 1250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err_size,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic [2:0] state
);

    localparam int unsigned Depth = MAX_N * MAX_N;
    localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned ElemB = ELEM_W / 8;
    localparam int unsigned AccB  = ACC_W / 8;
    localparam int unsigned EBW   = (ElemB > 1) ? $clog2(ElemB) : 1;
    localparam int unsigned ABW   = (AccB > 1) ? $clog2(AccB) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoadA   = 3'd1,
        StLoadB   = 3'd2,
        StCompute = 3'd3,
        StSend    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          n_q, n_d;
    logic [AW-1:0]       last_q, last_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [EBW-1:0]      lbyte_q, lbyte_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [3:0]          i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ABW-1:0]      sbyte_q, sbyte_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                done_q, done_d;
    logic                err_size_q, err_size_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_overrun_q, err_overrun_d;

    logic [ELEM_W-1:0]   a_mem [Depth];
    logic [ELEM_W-1:0]   b_mem [Depth];
    logic [ACC_W-1:0]    r_mem [Depth];
    logic                a_we, b_we, r_we;

    logic [ELEM_W-1:0]   elem_new;
    logic [AW-1:0]       a_rd, b_rd, r_wr;
    logic [2*ELEM_W-1:0] prod;
    logic [ACC_W-1:0]    mac;
    logic [AW-1:0]       nxt_addr, sel_addr;
    logic [ABW-1:0]      nxt_byte, sel_byte, byte_idx;
    logic [ACC_W-1:0]    rd_word;
    logic [7:0]          tx_byte;
    logic                k_last, j_last, i_last, send_last;

    // Bytes arrive MSB first, so each new byte shifts in at the bottom.
    assign elem_new = (elem_q << 8) | ELEM_W'(rx_data);

    assign a_rd = AW'({4'b0, i_q} * {4'b0, n_q} + {4'b0, k_q});
    assign b_rd = AW'({4'b0, k_q} * {4'b0, n_q} + {4'b0, j_q});
    assign r_wr = AW'({4'b0, i_q} * {4'b0, n_q} + {4'b0, j_q});
    assign prod = {{ELEM_W{1'b0}}, a_mem[a_rd]} * {{ELEM_W{1'b0}}, b_mem[b_rd]};
    assign mac  = ((k_q == 4'd0) ? '0 : acc_q) + ACC_W'(prod);

    assign k_last = (k_q == n_q - 4'd1);
    assign j_last = (j_q == n_q - 4'd1);
    assign i_last = (i_q == n_q - 4'd1);

    // While a byte is on the bus, look ahead to the byte that follows its acceptance.
    assign nxt_byte  = (sbyte_q == ABW'(AccB - 1)) ? '0 : sbyte_q + ABW'(1);
    assign nxt_addr  = (sbyte_q == ABW'(AccB - 1)) ? addr_q + AW'(1) : addr_q;
    assign sel_addr  = tx_valid_q ? nxt_addr : addr_q;
    assign sel_byte  = tx_valid_q ? nxt_byte : sbyte_q;
    assign rd_word   = r_mem[sel_addr];
    assign byte_idx  = ABW'(AccB - 1) - sel_byte;
    assign tx_byte   = rd_word[{byte_idx, 3'b000} +: 8];
    assign send_last = (sbyte_q == ABW'(AccB - 1)) && (addr_q == last_q);

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        last_d        = last_q;
        addr_d        = addr_q;
        lbyte_d       = lbyte_q;
        elem_d        = elem_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        acc_d         = acc_q;
        sbyte_d       = sbyte_q;
        tmo_d         = tmo_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        done_d        = 1'b0;
        err_size_d    = err_size_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;
        a_we          = 1'b0;
        b_we          = 1'b0;
        r_we          = 1'b0;

        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (rx_data != 8'd0 && rx_data <= 8'(MAX_N)) begin
                        n_d           = rx_data[3:0];
                        last_d        = AW'({4'b0, rx_data[3:0]} * {4'b0, rx_data[3:0]} - 8'd1);
                        err_size_d    = 1'b0;
                        err_timeout_d = 1'b0;
                        err_overrun_d = 1'b0;
                        addr_d        = '0;
                        lbyte_d       = '0;
                        sbyte_d       = '0;
                        i_d           = '0;
                        j_d           = '0;
                        k_d           = '0;
                        state_d       = StLoadA;
                    end else begin
                        err_size_d = 1'b1;
                    end
                end
            end
            StLoadA, StLoadB: begin
                if (rx_valid) begin
                    tmo_d  = '0;
                    elem_d = elem_new;
                    if (lbyte_q == EBW'(ElemB - 1)) begin
                        lbyte_d = '0;
                        a_we    = (state_q == StLoadA);
                        b_we    = (state_q == StLoadB);
                        if (addr_q == last_q) begin
                            addr_d  = '0;
                            state_d = (state_q == StLoadA) ? StLoadB : StCompute;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end else begin
                        lbyte_d = lbyte_q + EBW'(1);
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT_CYC)) begin
                        err_timeout_d = 1'b1;
                        tmo_d         = '0;
                        addr_d        = '0;
                        lbyte_d       = '0;
                        state_d       = StIdle;
                    end
                end
            end
            StCompute: begin
                acc_d = mac;
                r_we  = k_last;
                if (k_last) begin
                    k_d = '0;
                    if (j_last) begin
                        j_d = '0;
                        if (i_last) begin
                            i_d     = '0;
                            state_d = StSend;
                        end else begin
                            i_d = i_q + 4'd1;
                        end
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StSend: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = tx_byte;
                end else if (tx_ready) begin
                    if (send_last) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        addr_d     = '0;
                        sbyte_d    = '0;
                        state_d    = StIdle;
                    end else begin
                        addr_d    = nxt_addr;
                        sbyte_d   = nxt_byte;
                        tx_data_d = tx_byte;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Bytes arriving while the engine is not listening are dropped.
        if (rx_valid && (state_q == StCompute || state_q == StSend)) begin
            err_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            n_q           <= '0;
            last_q        <= '0;
            addr_q        <= '0;
            lbyte_q       <= '0;
            elem_q        <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            sbyte_q       <= '0;
            tmo_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            err_size_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            lbyte_q       <= lbyte_d;
            elem_q        <= elem_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            sbyte_q       <= sbyte_d;
            tmo_q         <= tmo_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            done_q        <= done_d;
            err_size_q    <= err_size_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) a_mem[addr_q] <= elem_new;
        if (b_we) b_mem[addr_q] <= elem_new;
        if (r_we) r_mem[r_wr] <= mac;
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);
    assign err_size    = err_size_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign state       = state_q;

endmodule

// File: doc/uart_matmul_engine.md
# uart_matmul_engine

Runtime-sized square matrix multiplier for the UART matrix datapath. It sits between the UART receiver's byte output and the UART transmitter's byte input. It accepts a size header, then matrices A and B as a byte stream, and computes R = A×B with one multiply-accumulate per cycle. It returns R as a back-pressured byte stream. Compared with the fixed 10×10 design, it adds a runtime N, configurable element and accumulator widths, a valid/ready transmit handshake, an inter-byte timeout and error reporting.

## Interface
- MAX_N, 10: largest supported N. Legal range 1..15.
- ELEM_W, 8: operand width in bits. Must be 8 or 16. Operands are unsigned and sent as ELEM_W/8 bytes, MSB first.
- ACC_W, 24: result width in bits. Must be a multiple of 8. Results are sent as ACC_W/8 bytes, MSB first.
- TIMEOUT_CYC, 1250000: maximum clk cycles allowed between received bytes during a load. A value of 0 disables the timeout.
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset, synchronous and active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid. The UART done edge drives this input.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the transmitter accepts tx_data this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result byte is accepted.
- err_size  out  1  sticky: a header was outside 1..MAX_N.
- err_timeout  out  1  sticky: a load was aborted by the timeout.
- err_overrun  out  1  sticky: rx_valid arrived during COMPUTE or SEND.
- state  out  3  current state encoding, for debug and LEDs.

## Operation
- Reset value of every output is 0. State resets to IDLE (0) and all counters reset to 0. Matrix RAM contents are not reset.
- Sticky error flags clear only on rst, or on acceptance of a valid header.
- Storage: A and B each hold MAX_N² entries of ELEM_W bits. R holds MAX_N² entries of ACC_W bits. All three are row-major; element (r,c) sits at address r*N+c.
- IDLE (0): wait for a header byte h.
  - If 1 ≤ h ≤ MAX_N: set N = h, clear the error flags, and go to LOAD_A.
  - Otherwise: set err_size and stay in IDLE.
- LOAD_A (1) and LOAD_B (2): assemble N² elements from ELEM_W/8 bytes each, MSB first.
  - LOAD_A moves to LOAD_B after the last byte of A.
  - LOAD_B moves to COMPUTE after the last byte of B.
- COMPUTE (3): loop i, j, k with k innermost, each over 0..N-1.
  - acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j], every cycle.
  - When k==N-1, write acc+product to R[i][j].
  - Arithmetic is modulo 2^ACC_W. Overflow wraps with no flag.
  - After i=j=k=N-1, go to SEND.
- SEND (4): stream R in row-major order, ACC_W/8 bytes per element, MSB first.
  - When the last byte is accepted, pulse done and return to IDLE.
- Timeout: in LOAD_A or LOAD_B, if TIMEOUT_CYC cycles pass with no rx_valid:
  - set err_timeout;
  - go to IDLE;
  - discard the partial data.
- rx_valid in COMPUTE or SEND: set err_overrun and drop the byte. The operation continues.
- rst at any time, including mid-load or mid-send, returns the block to IDLE on the next clk edge.
  - tx_valid is low in that same cycle.
  - No partial result byte is re-sent.

## Timing
- A byte is consumed on a clk edge where rx_valid=1. Back-to-back rx_valid strobes on consecutive cycles must be handled.
- The last B byte is accepted at edge t. COMPUTE occupies edges t+1 .. t+N³.
- tx_valid first rises after edge t+N³+1. First-result latency is therefore N³+1 cycles.
- Handshake:
  - A byte transfers on an edge where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable.
  - tx_valid may not drop until the byte is accepted.
  - The next byte is presented on the cycle after acceptance. Maximum throughput is one byte per cycle.
- done is high for exactly the one cycle after the final transfer edge. On that same cycle busy falls and state=0.
- Timeout counter:
  - restarts on every accepted byte, including the header;
  - fires when it reaches TIMEOUT_CYC;
  - the abort happens on that edge.
- A header and the timeout can coincide only in IDLE, where the timeout is inactive. If rx_valid and the timeout coincide in LOAD, the byte wins and the counter restarts.

## Test plan
- Identity (ELEM_W=8, ACC_W=24): send N=2, A=[1,2,3,4], B=[1,0,0,1] with tx_ready=1.
  - Required: 12 bytes out: 00 00 01 00 00 02 00 00 03 00 00 04.
  - done pulses once; 9 cycles from last B byte to first tx_valid.
- Max size: send N=10, all A and B elements = 0xFF.
  - Required: 100 results, each 0x09EC0A (650250), sent as 09 EC 0A repeated.
  - Back-to-back rx_valid must lose no bytes.
- Bad header: send header 0, then 11.
  - Required: err_size=1, state stays 0, no tx_valid.
  - A following valid header 2 clears err_size.
- Backpressure: during SEND, hold tx_ready low for 50 cycles.
  - Required: tx_valid stays 1 with tx_data constant.
  - The byte stream is otherwise identical to the unstalled run.
- Timeout and overrun:
  - Stop after 3 bytes of A with TIMEOUT_CYC=100. Required: err_timeout=1 and state=0 after exactly 100 idle cycles.
  - Inject rx_valid during COMPUTE. Required: err_overrun=1 and results unchanged.
- Reset mid-operation: assert rst for 1 cycle in the middle of LOAD_B and in the middle of SEND.
  - Required: all outputs 0 and state=0 on the next cycle.
  - A fresh N=1 run, A=[7], B=[6], returns 00 00 2A.
